// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired control unit: fetch/execute state sequence with Moore control strobes
// Strobes are decoded from the state register and the opcode only; Stop only steers the edge back into T0.
module control_sequencer (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        Stop,
   output logic        PCout,
   output logic        ZLowout,
   output logic        MDRout,
   output logic        Cout,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        MAR_enable,
   output logic        MDR_enable,
   output logic        IR_enable,
   output logic        Y_enable,
   output logic        Z_low_enable,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic [4:0]  operation,
   output logic        Run
);

   typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

   state_t     state;
   logic [4:0] opcode;
   logic       is_rfmt, is_imm, is_ldi, is_ld, is_st, is_halt;
   logic       is_mem, is_addr, executes;
   logic       unused_ir_bits;

   assign opcode         = IR[31:27];
   assign unused_ir_bits = ^IR[26:0];

   assign is_rfmt  = (opcode >= 5'd3) && (opcode <= 5'd6);
   assign is_imm   = (opcode >= 5'd12) && (opcode <= 5'd14);
   assign is_ld    = (opcode == 5'd0);
   assign is_ldi   = (opcode == 5'd1);
   assign is_st    = (opcode == 5'd2);
   assign is_halt  = (opcode == 5'd27);
   assign is_mem   = is_ld | is_st;
   assign is_addr  = is_ldi | is_mem;
   assign executes = is_rfmt | is_imm | is_addr;

   // Every path back into T0 goes through the Stop check so an instruction always finishes first.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= RST;
      end else begin
         case (state)
            RST:     state <= T0;
            T0:      state <= T1;
            T1:      state <= T2;
            T2:      state <= T3;
            T3: begin
               if (is_halt)       state <= HALT;
               else if (executes) state <= T4;
               else               state <= Stop ? HALT : T0;
            end
            T4:      state <= T5;
            T5: begin
               if (is_mem) state <= T6;
               else        state <= Stop ? HALT : T0;
            end
            T6:      state <= T7;
            T7:      state <= Stop ? HALT : T0;
            HALT:    state <= HALT;
            default: state <= RST;
         endcase
      end
   end

   always_comb begin
      PCout        = 1'b0;
      ZLowout      = 1'b0;
      MDRout       = 1'b0;
      Cout         = 1'b0;
      Gra          = 1'b0;
      Grb          = 1'b0;
      Grc          = 1'b0;
      Rin          = 1'b0;
      Rout         = 1'b0;
      BAout        = 1'b0;
      MAR_enable   = 1'b0;
      MDR_enable   = 1'b0;
      IR_enable    = 1'b0;
      Y_enable     = 1'b0;
      Z_low_enable = 1'b0;
      IncPC        = 1'b0;
      Read         = 1'b0;
      Write        = 1'b0;
      operation    = 5'd0;
      Run          = (state != RST) && (state != HALT);
      case (state)
         T0: begin
            PCout      = 1'b1;
            MAR_enable = 1'b1;
            IncPC      = 1'b1;
         end
         T1: begin
            Read       = 1'b1;
            MDR_enable = 1'b1;
         end
         T2: begin
            MDRout    = 1'b1;
            IR_enable = 1'b1;
         end
         T3: begin
            if (is_rfmt || is_imm) begin
               Grb      = 1'b1;
               Rout     = 1'b1;
               Y_enable = 1'b1;
            end else if (is_addr) begin
               Grb      = 1'b1;
               BAout    = 1'b1;
               Y_enable = 1'b1;
            end
         end
         T4: begin
            // Immediate opcodes sit 9 above their register-format ALU codes.
            if (is_rfmt) begin
               Grc          = 1'b1;
               Rout         = 1'b1;
               Z_low_enable = 1'b1;
               operation    = opcode;
            end else if (is_imm) begin
               Cout         = 1'b1;
               Z_low_enable = 1'b1;
               operation    = opcode - 5'd9;
            end else if (is_addr) begin
               Cout         = 1'b1;
               Z_low_enable = 1'b1;
               operation    = 5'd3;
            end
         end
         T5: begin
            if (is_mem) begin
               ZLowout    = 1'b1;
               MAR_enable = 1'b1;
            end else if (is_rfmt || is_imm || is_ldi) begin
               ZLowout = 1'b1;
               Gra     = 1'b1;
               Rin     = 1'b1;
            end
         end
         T6: begin
            if (is_ld) begin
               Read       = 1'b1;
               MDR_enable = 1'b1;
            end else if (is_st) begin
               Gra        = 1'b1;
               Rout       = 1'b1;
               MDR_enable = 1'b1;
            end
         end
         T7: begin
            if (is_ld) begin
               MDRout = 1'b1;
               Gra    = 1'b1;
               Rin    = 1'b1;
            end else if (is_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench: per-instruction strobe tables vs. sampled control word
// Stimulus pushes one expected control word per clock; a monitor pops and compares on every falling edge.
module tb_control_sequencer;

   logic        clock;
   logic        clear;
   logic [31:0] IR;
   logic        Stop;
   logic        PCout, ZLowout, MDRout, Cout, Gra, Grb, Grc, Rin, Rout, BAout;
   logic        MAR_enable, MDR_enable, IR_enable, Y_enable, Z_low_enable;
   logic        IncPC, Read, Write, Run;
   logic [4:0]  operation;

   control_sequencer dut (
      .clock(clock), .clear(clear), .IR(IR), .Stop(Stop),
      .PCout(PCout), .ZLowout(ZLowout), .MDRout(MDRout), .Cout(Cout),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
      .Y_enable(Y_enable), .Z_low_enable(Z_low_enable), .IncPC(IncPC),
      .Read(Read), .Write(Write), .operation(operation), .Run(Run)
   );

   localparam logic [23:0] WR   = 24'h000001, RD   = 24'h000002, INC  = 24'h000004;
   localparam logic [23:0] ZE   = 24'h000008, YE   = 24'h000010, IRE  = 24'h000020;
   localparam logic [23:0] MDRE = 24'h000040, MARE = 24'h000080, BA   = 24'h000100;
   localparam logic [23:0] ROUT = 24'h000200, RIN  = 24'h000400, GRC  = 24'h000800;
   localparam logic [23:0] GRB  = 24'h001000, GRA  = 24'h002000, COUT = 24'h004000;
   localparam logic [23:0] MDRO = 24'h008000, ZLO  = 24'h010000, PCO  = 24'h020000;
   localparam logic [23:0] RUN  = 24'h800000;

   logic [23:0] dut_word;
   assign dut_word = {Run, operation, PCout, ZLowout, MDRout, Cout, Gra, Grb, Grc, Rin,
                      Rout, BAout, MAR_enable, MDR_enable, IR_enable, Y_enable,
                      Z_low_enable, IncPC, Read, Write};

   logic [23:0] exp_q[$];
   logic [23:0] plan[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_on   = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [23:0] op(input logic [4:0] x);
      return {1'b0, x, 18'b0};
   endfunction

   function automatic void check(input string name, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endfunction

   // Strobe table per instruction class, T0 first; length is the instruction latency.
   task automatic build_plan(input logic [4:0] opc);
      logic [23:0] t3_addr, t4_addr, t5_wb;
      plan.delete();
      plan.push_back(RUN | PCO | MARE | INC);
      plan.push_back(RUN | RD | MDRE);
      plan.push_back(RUN | MDRO | IRE);
      t3_addr = RUN | GRB | BA | YE;
      t4_addr = RUN | COUT | ZE | op(5'd3);
      t5_wb   = RUN | ZLO | GRA | RIN;
      if (opc >= 5'd3 && opc <= 5'd6) begin
         plan.push_back(RUN | GRB | ROUT | YE);
         plan.push_back(RUN | GRC | ROUT | ZE | op(opc));
         plan.push_back(t5_wb);
      end else if (opc >= 5'd12 && opc <= 5'd14) begin
         plan.push_back(RUN | GRB | ROUT | YE);
         plan.push_back(RUN | COUT | ZE | op(opc - 5'd9));
         plan.push_back(t5_wb);
      end else if (opc == 5'd1) begin
         plan.push_back(t3_addr);
         plan.push_back(t4_addr);
         plan.push_back(t5_wb);
      end else if (opc == 5'd0) begin
         plan.push_back(t3_addr);
         plan.push_back(t4_addr);
         plan.push_back(RUN | ZLO | MARE);
         plan.push_back(RUN | RD | MDRE);
         plan.push_back(RUN | MDRO | GRA | RIN);
      end else if (opc == 5'd2) begin
         plan.push_back(t3_addr);
         plan.push_back(t4_addr);
         plan.push_back(RUN | ZLO | MARE);
         plan.push_back(RUN | GRA | ROUT | MDRE);
         plan.push_back(RUN | WR);
      end else begin
         plan.push_back(RUN);
      end
   endtask

   task automatic step(input logic [23:0] w);
      exp_q.push_back(w);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int n);
      clear = 1'b1;
      Stop  = 1'b0;
      repeat (n) step('0);
      clear = 1'b0;
      step('0);
   endtask

   // Stop is high over cycles [stop_at, stop_at+stop_len); clr_at pulses clear mid-cycle at that index.
   task automatic run_instr(input logic [4:0] opc, input logic [26:0] low,
                            input int stop_at, input int stop_len, input int clr_at);
      int last;
      bit halted;
      build_plan(opc);
      last   = plan.size() - 1;
      halted = (opc == 5'd27) ||
               (stop_at >= 0 && stop_at <= last && stop_at + stop_len > last);
      for (int k = 0; k <= last; k++) begin
         if (k == 3) IR = {opc, low};
         if (stop_at >= 0 && k == stop_at) Stop = 1'b1;
         if (stop_at >= 0 && k == stop_at + stop_len) Stop = 1'b0;
         if (k == clr_at) begin
            exp_q.push_back('0);
            #2 clear = 1'b1;
            #1 check("clear_async", dut_word, '0);
            @(posedge clock);
            #1;
            do_reset(2);
            return;
         end
         step(plan[k]);
      end
      if (halted) begin
         for (int h = 0; h < 20; h++) begin
            if (h == 5) Stop = 1'b0;
            step(RUN & 24'h0);
         end
         do_reset(2);
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (mon_on) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL cycle_word: no expected entry, got %h at %0t", dut_word, $time);
            end else begin
               check("cycle_word", dut_word, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [4:0] pick[12];
      logic [4:0] opc;
      int         s_at, s_len, c_at;
      pick = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd26, 5'd27};
      clear = 1'b1;
      Stop  = 1'b0;
      IR    = 32'h0;
      @(posedge clock);
      #1;
      mon_on = 1'b1;
      do_reset(3);

      run_instr(5'd3,  27'd0, -1, 0, -1);
      run_instr(5'd2,  27'h123456, -1, 0, -1);
      run_instr(5'd13, 27'h0abcde, 4, 100, -1);
      run_instr(5'd0,  27'h000777, -1, 0, 6);
      run_instr(5'd31, 27'h1, -1, 0, -1);
      run_instr(5'd26, 27'h2, -1, 0, -1);
      run_instr(5'd2,  27'h3, -1, 0, 7);
      run_instr(5'd4,  27'h4, 4, 1, -1);
      run_instr(5'd1,  27'h5, 1, 2, -1);
      run_instr(5'd27, 27'h6, -1, 0, -1);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) opc = 5'($urandom);
         else                           opc = pick[$urandom_range(0, 11)];
         s_at = -1; s_len = 0; c_at = -1;
         if ($urandom_range(0, 7) == 0) begin
            s_at  = $urandom_range(0, 7);
            s_len = $urandom_range(1, 8);
         end
         if ($urandom_range(0, 15) == 0) c_at = $urandom_range(0, 7);
         run_instr(opc, 27'($urandom), s_at, s_len, c_at);
      end

      mon_on = 1'b0;
      check("queue_drain", 24'(exp_q.size()), 24'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
